// File: rtl/knights_pkg.sv
// Shared command types and opcode constants for the knight's-tour command path.
// Opcode lives in the top nibble of each 16-bit BLE command.
package knights_pkg;

  localparam int CMD_W = 16;

  typedef logic [CMD_W-1:0] cmd_t;

  localparam logic [3:0] CMD_CAL  = 4'h2;
  localparam logic [3:0] CMD_MOVE = 4'h4;
  localparam logic [3:0] CMD_TOUR = 4'h6;

  function automatic cmd_t mk_cmd(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// Purpose: DEPTH x CMD_W command storage, one write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller guarantees writes only target free slots.
module cmd_fifo_mem
  import knights_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CMD_W = knights_pkg::CMD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CMD_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CMD_W-1:0] rdata
);

  logic [CMD_W-1:0] mem [DEPTH];

  // Cleared on reset so the head reads back as zero while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ble_cmd_queue.sv
// Purpose: command FIFO between UART_wrapper and TourCmd; optional QUEUE_OVF_EN adds sticky overwrite detection.
// Latency: accept at edge N gives a 1-cycle in_clr_cmd_rdy pulse; head valid at edge N+1 when empty.
// Backpressure: while full no accept is issued and upstream keeps in_cmd_rdy high.
module ble_cmd_queue
  import knights_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CMD_W = knights_pkg::CMD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CMD_W-1:0]         in_cmd,
  input  logic                     in_cmd_rdy,
  output logic                     in_clr_cmd_rdy,
  output logic [CMD_W-1:0]         out_cmd,
  output logic                     out_cmd_rdy,
  input  logic                     out_clr_cmd_rdy,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          clr_q, blk_q, rdy_q;
  logic          push, pop;

  assign full = (count_q == CW'(DEPTH));

  // Upstream clears cmd_rdy one cycle after seeing our pulse, so block both the
  // pulse cycle and the one after it to avoid capturing the same command twice.
  assign push = in_cmd_rdy && !full && !clr_q && !blk_q && !flush;
  assign pop  = out_clr_cmd_rdy && rdy_q && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      clr_q   <= 1'b0;
      blk_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      clr_q <= push;
      blk_q <= clr_q;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        rdy_q   <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        // One-cycle low gap after every pop mirrors UART_wrapper level semantics.
        rdy_q <= (count_q != '0) && !pop;
      end
    end
  end

  cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_cmd),
    .raddr (rd_ptr),
    .rdata (out_cmd)
  );

  assign in_clr_cmd_rdy = clr_q;
  assign out_cmd_rdy    = rdy_q;
  assign count          = count_q;

`ifdef QUEUE_OVF_EN
  logic [CMD_W-1:0] prev_cmd;
  logic             watch_q, ovf_q, overwrite;
  logic [7:0]       ovf_cnt;

  // A held-but-unaccepted command that changes value was lost upstream.
  assign overwrite = watch_q && in_cmd_rdy && full && (in_cmd != prev_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cmd <= '0;
      watch_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      prev_cmd <= in_cmd;
      watch_q  <= in_cmd_rdy && full && !push;
      if (overwrite) ovf_q <= 1'b1;
      if (overwrite && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ble_cmd_queue.sv
// Directed bench for ble_cmd_queue: handshake, fill/drain, pop gap, wrap, flush, overflow flag.
module tb_ble_cmd_queue;
  import knights_pkg::*;

`ifdef QUEUE_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] in_cmd;
  logic        in_cmd_rdy;
  logic        in_clr_cmd_rdy;
  logic [15:0] out_cmd;
  logic        out_cmd_rdy;
  logic        out_clr_cmd_rdy;
  logic        flush;
  logic [2:0]  count;
  logic        full;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  ble_cmd_queue #(.DEPTH(4), .CMD_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_cmd          (in_cmd),
    .in_cmd_rdy      (in_cmd_rdy),
    .in_clr_cmd_rdy  (in_clr_cmd_rdy),
    .out_cmd         (out_cmd),
    .out_cmd_rdy     (out_cmd_rdy),
    .out_clr_cmd_rdy (out_clr_cmd_rdy),
    .flush           (flush),
    .count           (count),
    .full            (full),
    .ovf             (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream model: hold in_cmd_rdy until the accept pulse, then drop it.
  task automatic push_cmd(input logic [15:0] c);
    logic got;
    got = 1'b0;
    in_cmd     = c;
    in_cmd_rdy = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_clr_cmd_rdy) got = 1'b1;
    end
    in_cmd_rdy = 1'b0;
    chk("push_accept", {31'd0, got}, 32'd1);
    if (got) exp_q.push_back(c);
  endtask

  // Downstream model: wait for head valid, check it against the model, pulse pop.
  task automatic pop_cmd();
    logic got;
    logic [15:0] e;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_cmd_rdy) got = 1'b1;
      else @(negedge clk);
    end
    chk("pop_rdy", {31'd0, got}, 32'd1);
    if (got && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pop_data", {16'd0, out_cmd}, {16'd0, e});
      out_clr_cmd_rdy = 1'b1;
      @(negedge clk);
      out_clr_cmd_rdy = 1'b0;
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_cmd = '0; in_cmd_rdy = 1'b0; out_clr_cmd_rdy = 1'b0; flush = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_out_rdy", {31'd0, out_cmd_rdy}, 32'd0);
    chk("rst_out_cmd", {16'd0, out_cmd}, 32'd0);
    chk("rst_clr", {31'd0, in_clr_cmd_rdy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: pulse, then head valid one cycle later
    in_cmd = mk_cmd(CMD_CAL, 12'h000);
    in_cmd_rdy = 1'b1;
    @(negedge clk);
    chk("single_clr", {31'd0, in_clr_cmd_rdy}, 32'd1);
    chk("single_cnt", {29'd0, count}, 32'd1);
    chk("single_rdy_early", {31'd0, out_cmd_rdy}, 32'd0);
    in_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("single_clr_done", {31'd0, in_clr_cmd_rdy}, 32'd0);
    chk("single_rdy", {31'd0, out_cmd_rdy}, 32'd1);
    chk("single_cmd", {16'd0, out_cmd}, 32'h2000);
    exp_q.push_back(16'h2000);

    // Pop gap with two entries
    push_cmd(16'h2001);
    repeat (2) @(negedge clk);
    chk("gap_cnt2", {29'd0, count}, 32'd2);
    chk("gap_head", {16'd0, out_cmd}, 32'h2000);
    out_clr_cmd_rdy = 1'b1;
    @(negedge clk);
    out_clr_cmd_rdy = 1'b0;
    void'(exp_q.pop_front());
    chk("gap_low", {31'd0, out_cmd_rdy}, 32'd0);
    chk("gap_cnt1", {29'd0, count}, 32'd1);
    @(negedge clk);
    chk("gap_high", {31'd0, out_cmd_rdy}, 32'd1);
    chk("gap_second", {16'd0, out_cmd}, 32'h2001);
    pop_cmd();
    repeat (2) @(negedge clk);
    out_clr_cmd_rdy = 1'b1;
    @(negedge clk);
    out_clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("empty_pop_cnt", {29'd0, count}, 32'd0);
    chk("empty_pop_rdy", {31'd0, out_cmd_rdy}, 32'd0);

    // Burst to full, fifth command waits for a pop
    for (int i = 1; i <= 4; i++) push_cmd(mk_cmd(CMD_MOVE, 12'(i)));
    @(negedge clk);
    chk("burst_full", {31'd0, full}, 32'd1);
    chk("burst_cnt", {29'd0, count}, 32'd4);
    in_cmd = 16'h4005;
    in_cmd_rdy = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (in_clr_cmd_rdy) seen = 1'b1;
    end
    chk("burst_no_accept", {31'd0, seen}, 32'd0);
    pop_cmd();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (in_clr_cmd_rdy) seen = 1'b1;
    end
    in_cmd_rdy = 1'b0;
    chk("burst_late_accept", {31'd0, seen}, 32'd1);
    chk("burst_cnt_refill", {29'd0, count}, 32'd4);
    exp_q.push_back(16'h4005);
    repeat (4) pop_cmd();
    repeat (2) @(negedge clk);
    chk("burst_drained", {29'd0, count}, 32'd0);

    // Simultaneous push and pop at count 2 across pointer wrap
    push_cmd(16'h8000);
    push_cmd(16'h8001);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("sim_rdy", {31'd0, out_cmd_rdy}, 32'd1);
      chk("sim_head", {16'd0, out_cmd}, {16'd0, exp_q[0]});
      in_cmd = 16'h8002 + 16'(i);
      in_cmd_rdy = 1'b1;
      out_clr_cmd_rdy = 1'b1;
      @(negedge clk);
      in_cmd_rdy = 1'b0;
      out_clr_cmd_rdy = 1'b0;
      chk("sim_accept", {31'd0, in_clr_cmd_rdy}, 32'd1);
      chk("sim_cnt", {29'd0, count}, 32'd2);
      void'(exp_q.pop_front());
      exp_q.push_back(16'h8002 + 16'(i));
      repeat (2) @(negedge clk);
    end
    pop_cmd();
    pop_cmd();
    repeat (2) @(negedge clk);
    chk("sim_drained", {29'd0, count}, 32'd0);

    // Flush beats a concurrent push; accept follows next cycle
    push_cmd(16'h9001);
    push_cmd(16'h9002);
    push_cmd(16'h9003);
    repeat (3) @(negedge clk);
    chk("flush_pre_cnt", {29'd0, count}, 32'd3);
    in_cmd = 16'h9100;
    in_cmd_rdy = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    chk("flush_cnt", {29'd0, count}, 32'd0);
    chk("flush_no_accept", {31'd0, in_clr_cmd_rdy}, 32'd0);
    chk("flush_rdy", {31'd0, out_cmd_rdy}, 32'd0);
    @(negedge clk);
    in_cmd_rdy = 1'b0;
    chk("flush_next_accept", {31'd0, in_clr_cmd_rdy}, 32'd1);
    chk("flush_next_cnt", {29'd0, count}, 32'd1);
    exp_q.push_back(16'h9100);
    pop_cmd();
    repeat (2) @(negedge clk);

    // Upstream overwrites an unaccepted command while full
    for (int i = 1; i <= 4; i++) push_cmd(mk_cmd(CMD_TOUR, 12'(i)));
    repeat (2) @(negedge clk);
    chk("ovf_full", {31'd0, full}, 32'd1);
    in_cmd = 16'h5000;
    in_cmd_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_before", {31'd0, ovf}, 32'd0);
    in_cmd = 16'h5001;
    repeat (2) @(negedge clk);
    chk("ovf_set", {31'd0, ovf}, {31'd0, EXP_OVF});
    in_cmd_rdy = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("ovf_flush_cnt", {29'd0, count}, 32'd0);
    chk("ovf_after_flush", {31'd0, ovf}, {31'd0, EXP_OVF});

    // Reset in the middle of a handshake cancels the pulse and drops data
    in_cmd = 16'h2abc;
    in_cmd_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_pulse", {31'd0, in_clr_cmd_rdy}, 32'd1);
    rst_n = 1'b0;
    in_cmd_rdy = 1'b0;
    #1;
    chk("midrst_clr", {31'd0, in_clr_cmd_rdy}, 32'd0);
    chk("midrst_cnt", {29'd0, count}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_rdy", {31'd0, out_cmd_rdy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
